// File: rtl/fp_normalize_64_pkg.sv
// rtl/fp_normalize_64_pkg.sv - shared FPU constants and unnormalised-operand type
package fp_normalize_64_pkg;

  localparam int MANT64_W = 64;
  localparam int CLZ64_W  = 7;
  localparam int FP_EXP_W = 13;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [MANT64_W-1:0] mant;
  } fp_unnorm_t;

endpackage

// File: rtl/fp_normalize_64_if.sv
// rtl/fp_normalize_64_if.sv - input/output handshake bundle of the normaliser
interface fp_normalize_64_if
  import fp_normalize_64_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W
);

  logic                in_valid;
  logic                in_ready;
  logic                in_sign;
  logic [EXP_W-1:0]    in_exp;
  logic [MANT64_W-1:0] in_mant;

  logic                out_valid;
  logic                out_ready;
  logic                out_sign;
  logic [EXP_W-1:0]    out_exp;
  logic [MANT64_W-1:0] out_mant;
  logic                out_zero;
  logic                out_denorm;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_mant, out_zero, out_denorm
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_mant, out_zero, out_denorm
  );

endinterface

// File: rtl/fp_normalize_64_clz.sv
// rtl/fp_normalize_64_clz.sv - 64-bit leading-zero counter, 64 for an all-zero word
module fp_normalize_64_clz
  import fp_normalize_64_pkg::*;
(
  input  logic [MANT64_W-1:0] mant_i,
  output logic [CLZ64_W-1:0]  clz_o
);

  // Scan upward so the highest set bit is the last to write the count.
  always_comb begin
    clz_o = CLZ64_W'(MANT64_W);
    for (int i = 0; i < MANT64_W; i++) begin
      if (mant_i[i]) clz_o = CLZ64_W'(MANT64_W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_normalize_64.sv
// rtl/fp_normalize_64.sv - two-stage significand normaliser with EXP_MIN clamp
module fp_normalize_64
  import fp_normalize_64_pkg::*;
#(
  parameter int EXP_W   = FP_EXP_W,
  parameter int EXP_MIN = -1022
) (
  input logic               clk,
  input logic               reset,
  fp_normalize_64_if.slave  bus
);

  localparam logic signed [EXP_W:0] EXP_MIN_W = (EXP_W+1)'(EXP_MIN);

  logic                    s1_valid_q;
  fp_unnorm_t              s1_q;
  logic [CLZ64_W-1:0]      s1_clz_q;
  logic signed [EXP_W:0]   s1_lim_q;

  logic                    out_valid_q;
  logic                    out_sign_q;
  logic [EXP_W-1:0]        out_exp_q;
  logic [MANT64_W-1:0]     out_mant_q;
  logic                    out_zero_q;
  logic                    out_denorm_q;

  logic                    s1_adv;
  logic                    s2_adv;
  logic [CLZ64_W-1:0]      clz_d;
  logic signed [EXP_W:0]   lim_d;
  logic signed [EXP_W:0]   clz_w;
  logic signed [EXP_W:0]   sh_w;
  logic                    zero_d;
  logic [MANT64_W-1:0]     mant_d;
  logic [EXP_W-1:0]        exp_d;
  logic                    denorm_d;

  assign s2_adv       = !out_valid_q || bus.out_ready;
  assign s1_adv       = !s1_valid_q || s2_adv;
  assign bus.in_ready = s1_adv;

  fp_normalize_64_clz u_clz (
    .mant_i (bus.in_mant),
    .clz_o  (clz_d)
  );

  assign lim_d = $signed({bus.in_exp[EXP_W-1], bus.in_exp}) - EXP_MIN_W;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s1_clz_q   <= '0;
      s1_lim_q   <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_q     <= '{sign: bus.in_sign, exp: bus.in_exp, mant: bus.in_mant};
        s1_clz_q <= clz_d;
        s1_lim_q <= lim_d;
      end
    end
  end

  assign clz_w = $signed((EXP_W+1)'(s1_clz_q));

  // A negative limit means the input already sits below EXP_MIN: pass it through unshifted.
  always_comb begin
    sh_w = '0;
    if (!s1_lim_q[EXP_W]) sh_w = (clz_w < s1_lim_q) ? clz_w : s1_lim_q;
    zero_d   = (s1_clz_q == CLZ64_W'(MANT64_W));
    mant_d   = s1_q.mant << sh_w[5:0];
    exp_d    = s1_q.exp - sh_w[EXP_W-1:0];
    denorm_d = !zero_d && (sh_w < clz_w);
    if (zero_d) begin
      mant_d   = '0;
      exp_d    = EXP_MIN_W[EXP_W-1:0];
      denorm_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_sign_q   <= 1'b0;
      out_exp_q    <= '0;
      out_mant_q   <= '0;
      out_zero_q   <= 1'b0;
      out_denorm_q <= 1'b0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_sign_q   <= s1_q.sign;
        out_exp_q    <= exp_d;
        out_mant_q   <= mant_d;
        out_zero_q   <= zero_d;
        out_denorm_q <= denorm_d;
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_sign   = out_sign_q;
  assign bus.out_exp    = out_exp_q;
  assign bus.out_mant   = out_mant_q;
  assign bus.out_zero   = out_zero_q;
  assign bus.out_denorm = out_denorm_q;

endmodule
